uart_tx_arbiter: RTL and testbench

- Shares one 8N1 UART serializer (data/load input, no busy output) between NUM_REQ byte producers.
- Performs round-robin arbitration, presents the winning byte with a one-cycle load pulse, then blocks for a fixed frame time so the serializer is idle before the next load.
- Sits between the producers (status reporter, debug dump, command responder) and the serializer.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// frame geometry and the bit-period helper.
package uart_pkg;

    // Arbiter phases: arbitrate, present the byte for one cycle, wait out the frame.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_LOAD = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    // One 8N1 frame: start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS   = 10;

    // Extra clocks added to the wait so the serializer is certainly idle
    // before the next load arrives.
    localparam int FRAME_MARGIN = 2;

    // Clocks per serial bit for a given clock frequency and baud rate.
    function automatic int calc_bit_clks(input int freq, input int baud);
        return freq / baud;
    endfunction

    // Clocks the arbiter stays in its wait phase after a load.
    function automatic int calc_frame_clks(input int bit_clks);
        return (FRAME_BITS * bit_clks) + FRAME_MARGIN;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter. The search starts at ptr and
// wraps modulo NUM_REQ; the first set request wins. Tying ptr to zero turns
// it into a plain lowest-index-wins priority encoder.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               valid
);

    int              cand_s;
    logic [ID_W-1:0] cand_idx_s;

    // Scan the requests starting at ptr and pick the first one that is set.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        valid      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = int'(ptr) + k;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = ID_W'(cand_s);
            if (!valid && req[cand_idx_s]) begin
                valid             = 1'b1;
                grant[cand_idx_s] = 1'b1;
                grant_idx         = cand_idx_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART serializer between NUM_REQ byte producers.
// A winner is chosen in IDLE, its byte is presented with a one-cycle load
// pulse and ack, then the block waits a full frame time (plus margin) so
// the serializer, which has no busy output, is idle before the next load.
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority
// (lowest set index wins, no rotating pointer); default is round-robin.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FREQ    = 27000000,
    parameter int BAUD    = 3000000
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_REQ-1:0]                              req,
    input  logic [8*NUM_REQ-1:0]                            req_data,
    output logic [NUM_REQ-1:0]                              ack,
    output logic [7:0]                                      tx_data,
    output logic                                            tx_load,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                            busy
);

    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BIT_CLKS   = calc_bit_clks(FREQ, BAUD);
    localparam int FRAME_CLKS = calc_frame_clks(BIT_CLKS);
    localparam int CNT_W      = $clog2(FRAME_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    arb_state_e           state_q,    state_d;
    logic [NUM_REQ-1:0]   ack_q,      ack_d;
    logic [7:0]           tx_data_q,  tx_data_d;
    logic                 tx_load_q,  tx_load_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 busy_q,     busy_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;

    logic [ID_W-1:0]      arb_ptr_s;
    logic [NUM_REQ-1:0]   win_grant_s;
    logic [ID_W-1:0]      win_idx_s;
    logic                 win_valid_s;
    logic                 grant_now_s;

    // A grant happens only when arbitrating in IDLE with some request present.
    assign grant_now_s = (state_q == ARB_IDLE) && win_valid_s;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Fixed priority: search always starts at requester 0.
    assign arb_ptr_s = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Advance the rotating pointer past the winner, wrapping to 0 after the last requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_now_s) begin
            if (win_idx_s == ID_LAST) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx_s + ID_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Rotating pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign arb_ptr_s = rr_ptr_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (arb_ptr_s),
        .grant     (win_grant_s),
        .grant_idx (win_idx_s),
        .valid     (win_valid_s)
    );

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_load_d  = 1'b0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid_s) begin
                    tx_data_d  = req_data[8*win_idx_s +: 8];
                    tx_load_d  = 1'b1;
                    ack_d      = win_grant_s;
                    grant_id_d = win_idx_s;
                    busy_d     = 1'b1;
                    state_d    = ARB_LOAD;
                end else begin
                    state_d    = ARB_IDLE;
                end
            end
            ARB_LOAD: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    busy_d  = 1'b0;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, frame counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            ack_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_load_q  <= 1'b0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_load_q  <= tx_load_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_load  = tx_load_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// randomized requesters, all compared cycle by cycle against a reference
// model that treats the arbiter as "grant, then unavailable for a fixed
// number of cycles". A small serializer model checks the line behaviour.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FREQ       = 27000000;
    localparam int BAUD       = 3000000;
    localparam int BIT_CLKS   = FREQ / BAUD;
    localparam int FRAME_CLKS = 10 * BIT_CLKS + 2;
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           tx_data;
    logic                 tx_load;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .FREQ    (FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- serializer model (8N1, LSB first) ----------------
    int         ser_left;
    logic [9:0] ser_frame;
    logic       ser_tx;
    logic       ser_busy;
    int         ser_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_left  <= 0;
            ser_frame <= 10'h3FF;
        end else if (ser_left == 0) begin
            if (tx_load) begin
                ser_frame <= {1'b1, tx_data, 1'b0};
                ser_left  <= 10 * BIT_CLKS;
            end
        end else begin
            ser_left <= ser_left - 1;
        end
    end

    always_comb begin
        ser_idx  = (10 * BIT_CLKS - ser_left) / BIT_CLKS;
        ser_busy = (ser_left != 0);
        if (ser_left == 0) ser_tx = 1'b1;
        else               ser_tx = ser_frame[ser_idx[3:0]];
    end

    // ---------------- reference model ----------------
    int                 m_rem;   // cycles the arbiter stays unavailable
    int                 m_ptr;
    logic [NUM_REQ-1:0] e_ack;
    logic               e_load;
    logic               e_busy;
    logic [7:0]         e_data;
    int                 e_gid;

    task automatic model_reset();
        m_rem = 0; m_ptr = 0;
        e_ack = '0; e_load = 1'b0; e_busy = 1'b0; e_data = 8'h00; e_gid = 0;
    endtask

    // Predict the outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        int w;
        e_ack  = '0;
        e_load = 1'b0;
        if (m_rem > 0) begin
            m_rem--;
            e_busy = (m_rem > 0);
        end else if (req != '0) begin
            w = -1;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            for (int i = 0; i < NUM_REQ; i++)
                if (w < 0 && req[i]) w = i;
`else
            for (int k = 0; k < NUM_REQ; k++)
                if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
            m_ptr = (w + 1) % NUM_REQ;
`endif
            e_ack[w] = 1'b1;
            e_load   = 1'b1;
            e_data   = req_data[8*w +: 8];
            e_gid    = w;
            e_busy   = 1'b1;
            m_rem    = FRAME_CLKS + 1;   // LOAD cycle + WAIT cycles
        end
    endtask

    int load_cyc[$];
    int load_id[$];

    // One clock: predict, advance, then compare at the falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("ack",      ack,      e_ack);
        chk("tx_load",  tx_load,  e_load);
        chk("busy",     busy,     e_busy);
        chk("grant_id", grant_id, e_gid);
        chk("tx_data",  tx_data,  e_data);
        if (tx_load) begin
            chk("ser_idle_at_load", ser_busy, 1'b0);
            load_cyc.push_back(cyc);
            load_id.push_back(int'(grant_id));
        end
    endtask

    // Assert reset asynchronously, check the reset state, release on the next falling edge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        req = '0;
        #1;
        chk({tag, "_ack"},      ack,      '0);
        chk({tag, "_tx_load"},  tx_load,  1'b0);
        chk({tag, "_busy"},     busy,     1'b0);
        chk({tag, "_grant_id"}, grant_id, '0);
        chk({tag, "_tx_data"},  tx_data,  8'h00);
        chk({tag, "_line"},     ser_tx,   1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [9:0] s1_frame;
    int         blen;
    int         got;
    int         a3;
    int         nl;

    initial begin
        req      = '0;
        req_data = '0;
        rst      = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset("rst0");

        // S1: single request, frame shape on the line and busy length.
        req_data[15:8] = 8'h55;
        req            = 4'b0010;
        cycle();
        chk("s1_load", tx_load,  1'b1);
        chk("s1_ack",  ack,      4'b0010);
        chk("s1_data", tx_data,  8'h55);
        chk("s1_gid",  grant_id, 1);
        req      = '0;
        s1_frame = {1'b1, 8'h55, 1'b0};
        blen     = 1;
        for (int k = 1; k <= 200 && busy; k++) begin
            cycle();
            if (busy) blen++;
            if (((k - 1) % BIT_CLKS) == BIT_CLKS / 2 && ((k - 1) / BIT_CLKS) < 10)
                chk("s1_line", ser_tx, s1_frame[(k - 1) / BIT_CLKS]);
        end
        chk("s1_busy_len", blen, FRAME_CLKS + 1);

        // S2: all four requesting, rotation order and load spacing.
        do_reset("rst_s2");
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req      = 4'hF;
        load_cyc.delete();
        load_id.delete();
        for (int i = 0; i < 600 && load_cyc.size() < 5; i++) cycle();
        chk("s2_nloads", load_cyc.size(), 5);
        for (int i = 0; i < load_cyc.size(); i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            chk("s2_order", load_id[i], 0);
`else
            chk("s2_order", load_id[i], i % NUM_REQ);
`endif
            if (i > 0) chk("s2_gap", load_cyc[i] - load_cyc[i-1], FRAME_CLKS + 2);
        end

        // S3: req[2] granted, req[0] raised during the wait is served afterwards.
        do_reset("rst_s3");
        req_data[23:16] = 8'hC3;
        req             = 4'b0100;
        cycle();
        chk("s3_first_gid", grant_id, 2);
        req = '0;
        repeat (20) cycle();
        req[0]        = 1'b1;
        req_data[7:0] = 8'h3C;
        got = 0;
        for (int i = 0; i < 200 && got == 0; i++) begin
            cycle();
            if (tx_load) got = 1;
            else         chk("s3_no_ack_busy", ack, '0);
        end
        chk("s3_granted", got, 1);
        chk("s3_gid",     grant_id, 0);
        chk("s3_data",    tx_data, 8'h3C);
        req = '0;

        // S4: one-cycle req[3] pulse during the wait is dropped.
        repeat (10) cycle();
        req_data[31:24] = 8'h99;
        req             = 4'b1000;
        cycle();
        req = '0;
        nl  = load_cyc.size();
        a3  = 0;
        for (int i = 0; i < 150; i++) begin
            cycle();
            if (ack[3]) a3++;
        end
        chk("s4_no_ack3", a3, 0);
        chk("s4_no_load", load_cyc.size() - nl, 0);
        chk("s4_idle",    busy, 1'b0);

        // S5: reset 40 cycles into the wait, then pointer restarts from 0.
        do_reset("rst_s5a");
        req_data[23:16] = 8'hF0;
        req             = 4'b0100;
        cycle();
        req = '0;
        repeat (41) cycle();
        chk("s5_line_pre", ser_tx, 1'b0);
        do_reset("rst_mid");
        req_data[15:8]  = 8'h11;
        req_data[31:24] = 8'h33;
        req             = 4'b1010;
        cycle();
        chk("s5_load", tx_load,  1'b1);
        chk("s5_gid",  grant_id, 1);
        chk("s5_data", tx_data,  8'h11);
        req = '0;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 0 always beats requester 3.
        do_reset("rst_fp");
        req_data = {8'h33, 8'h22, 8'h11, 8'h00};
        req      = 4'b1001;
        nl       = load_cyc.size();
        a3       = 0;
        for (int i = 0; i < 500; i++) begin
            cycle();
            if (ack[3]) a3++;
        end
        chk("fp_no_ack3", a3, 0);
        chk("fp_nloads",  load_cyc.size() - nl, 6);
        for (int i = nl; i < load_cyc.size(); i++) chk("fp_gid", load_id[i], 0);
        req = '0;
`endif

        // Randomized requesters obeying the hold-until-ack handshake.
        do_reset("rst_rnd");
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    if (e_ack[i]) begin
                        if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                        else req_data[8*i +: 8] = 8'($urandom_range(255, 0));
                    end else if ($urandom_range(49, 0) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(5, 0) == 0) begin
                    req[i]             = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom_range(255, 0));
                end
            end
            if ($urandom_range(1499, 0) == 0) do_reset("rst_rand");
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
